// File: rtl/if_fetch_buf_if.sv
// if_fetch_buf_if: instruction bus between the fetch buffer (master) and memory (slave)
interface if_fetch_buf_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  modport master (output inst_req, inst_addr, input inst_addr_ok, inst_data_ok, inst_rdata);
  modport slave  (input inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: pc sequencer plus in-order instruction queue with flush discard and ADEF handling
module if_fetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          IQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  if_fetch_buf_if.master       bus,
  input  logic                 ex_flush,
  input  logic [31:0]          ex_pc,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  output logic                 if_valid,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_inst,
  output logic                 if_adef,
  input  logic                 id_allow_in
);
  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(IQ_DEPTH);
  logic [31:0] pc_q, pc_d;
  logic [31:0] qpc_q [IQ_DEPTH];
  logic [31:0] qpc_d [IQ_DEPTH];
  logic [31:0] qinst_q [IQ_DEPTH];
  logic [31:0] qinst_d [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] qadef_q, qadef_d, qfill_q, qfill_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, fidx;
  logic [CW-1:0] cnt_q, cnt_d, unf_q, unf_d, disc_q, disc_d;
  logic halt_q, halt_d, started_q;
  logic flush, hs, deq, fill, drop, late, adef_alloc, alloc;
  assign flush = ex_flush | br_taken;
  assign bus.inst_addr = pc_q;
  assign bus.inst_req = started_q & ~flush & (pc_q[1:0] == 2'b00) & ~halt_q &
                        (({1'b0, cnt_q} + {1'b0, disc_q}) < {1'b0, FULL});
  assign hs = bus.inst_req & bus.inst_addr_ok;
  assign if_valid = (cnt_q != '0) & qfill_q[head_q];
  assign if_pc = if_valid ? qpc_q[head_q] : '0;
  assign if_inst = if_valid ? qinst_q[head_q] : '0;
  assign if_adef = if_valid & qadef_q[head_q];
  assign deq = if_valid & id_allow_in & ~flush;
  assign drop = bus.inst_data_ok & (disc_q != '0);
  assign fill = bus.inst_data_ok & (disc_q == '0) & (unf_q != '0);
  assign late = bus.inst_data_ok & ((disc_q | unf_q) != '0);
  // a misaligned pc becomes one pre-filled fault entry, queued only behind already-filled entries
  assign adef_alloc = ~flush & (pc_q[1:0] != 2'b00) & ~halt_q & (unf_q == '0) & (cnt_q < FULL);
  assign alloc = hs | adef_alloc;
  // filled entries always form a prefix from the head, so the oldest unfilled one follows them
  assign fidx = head_q + PW'(cnt_q - unf_q);
  always_comb begin
    pc_d = flush ? (ex_flush ? ex_pc : br_target) : pc_q + (hs ? 32'd4 : 32'd0);
    qpc_d = qpc_q;
    qinst_d = qinst_q;
    qadef_d = qadef_q;
    qfill_d = qfill_q;
    head_d = flush ? '0 : head_q + PW'(deq);
    tail_d = flush ? '0 : tail_q + PW'(alloc);
    cnt_d = flush ? '0 : cnt_q + CW'(alloc) - CW'(deq);
    unf_d = flush ? '0 : unf_q + CW'(hs) - CW'(fill);
    disc_d = flush ? disc_q + unf_q - CW'(late) : disc_q - CW'(drop);
    halt_d = ~flush & (halt_q | adef_alloc);
    if (flush) qfill_d = '0;
    else begin
      if (fill) begin
        qinst_d[fidx] = bus.inst_rdata;
        qfill_d[fidx] = 1'b1;
      end
      if (deq) qfill_d[head_q] = 1'b0;
      if (alloc) begin
        qpc_d[tail_q] = pc_q;
        qinst_d[tail_q] = '0;
        qadef_d[tail_q] = adef_alloc;
        qfill_d[tail_q] = adef_alloc;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q <= RESET_PC;
      qpc_q <= '{default: '0};
      qinst_q <= '{default: '0};
      qadef_q <= '0;
      qfill_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      unf_q <= '0;
      disc_q <= '0;
      halt_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      qpc_q <= qpc_d;
      qinst_q <= qinst_d;
      qadef_q <= qadef_d;
      qfill_q <= qfill_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      unf_q <= unf_d;
      disc_q <= disc_d;
      halt_q <= halt_d;
      started_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_fetch_buf.sv
// tb_if_fetch_buf: directed scenarios plus randomized traffic, checked every cycle against a queue-level model
module tb_if_fetch_buf;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ex_flush, br_taken, id_allow_in, if_valid, if_adef;
  logic [31:0] ex_pc, br_target, if_pc, if_inst;
  if_fetch_buf_if bus ();
  if_fetch_buf #(.RESET_PC(RESET_PC), .IQ_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .ex_flush(ex_flush), .ex_pc(ex_pc), .br_taken(br_taken), .br_target(br_target),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_adef(if_adef),
    .id_allow_in(id_allow_in)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  int p_addr, p_data, p_allow;
  logic [31:0] memq[$];
  typedef struct {logic [31:0] pc; logic [31:0] inst; bit adef; bit filled;} ent_t;
  ent_t mq[$];
  logic [31:0] m_pc;
  int m_disc;
  bit m_halt, m_started;
  function automatic logic [31:0] h(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_3c3c;
  endfunction
  function automatic bit rnd(input int p);
    return $urandom_range(99) < p;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    else n_pass++;
  endtask
  function automatic int m_unf();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction
  function automatic bit m_req();
    return m_started && !(ex_flush || br_taken) && m_pc[1:0] == 2'b00 && !m_halt && (mq.size() + m_disc < DEPTH);
  endfunction
  function automatic bit m_valid();
    return mq.size() > 0 && mq[0].filled;
  endfunction
  task automatic m_reset();
    mq.delete();
    m_pc = RESET_PC;
    m_disc = 0;
    m_halt = 0;
    m_started = 0;
  endtask
  task automatic m_step();
    bit fl, hs, deq, adef, done;
    int unf;
    fl = ex_flush || br_taken;
    hs = m_req() && bus.inst_addr_ok;
    deq = m_valid() && id_allow_in;
    unf = m_unf();
    adef = !fl && m_pc[1:0] != 2'b00 && !m_halt && unf == 0 && mq.size() < DEPTH;
    if (fl) begin
      m_disc = m_disc + unf - ((bus.inst_data_ok && m_disc + unf > 0) ? 1 : 0);
      mq.delete();
      m_pc = ex_flush ? ex_pc : br_target;
      m_halt = 0;
    end else begin
      if (bus.inst_data_ok) begin
        if (m_disc > 0) m_disc--;
        else begin
          done = 0;
          for (int i = 0; i < mq.size(); i++)
            if (!done && !mq[i].filled) begin
              mq[i].filled = 1;
              mq[i].inst = h(mq[i].pc);
              done = 1;
            end
        end
      end
      if (deq) void'(mq.pop_front());
      if (hs) begin
        mq.push_back('{pc: m_pc, inst: 32'h0, adef: 1'b0, filled: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (adef) begin
        mq.push_back('{pc: m_pc, inst: 32'h0, adef: 1'b1, filled: 1'b1});
        m_halt = 1;
      end
    end
    m_started = 1;
  endtask
  // memory responder bookkeeping, model compare and model advance, all at the falling edge
  initial begin
    m_reset();
    forever begin
      @(negedge clk or negedge resetn);
      if (!resetn) begin
        memq.delete();
        m_reset();
        if (!clk) begin
          chk("rst_req", bus.inst_req, 0);
          chk("rst_addr", bus.inst_addr, RESET_PC);
          chk("rst_valid", if_valid, 0);
          chk("rst_adef", if_adef, 0);
          chk("rst_pc", if_pc, 0);
          chk("rst_inst", if_inst, 0);
        end
      end else begin
        chk("inst_req", bus.inst_req, m_req());
        chk("inst_addr", bus.inst_addr, m_pc);
        chk("if_valid", if_valid, m_valid());
        if (m_valid()) begin
          chk("if_pc", if_pc, mq[0].pc);
          chk("if_inst", if_inst, mq[0].inst);
          chk("if_adef", if_adef, mq[0].adef);
        end
        if (bus.inst_data_ok) void'(memq.pop_front());
        if (bus.inst_req && bus.inst_addr_ok) memq.push_back(bus.inst_addr);
        m_step();
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.inst_addr_ok = rnd(p_addr);
    bus.inst_data_ok = memq.size() > 0 && rnd(p_data);
    bus.inst_rdata = bus.inst_data_ok ? h(memq[0]) : $urandom;
    id_allow_in = rnd(p_allow);
    ex_flush = 0;
    br_taken = 0;
    ex_pc = $urandom;
    br_target = $urandom;
  endtask
  task automatic look();
    #3;
  endtask
  task automatic drain();
    p_addr = 0;
    p_data = 100;
    p_allow = 100;
    repeat (12) cyc();
  endtask
  function automatic logic [31:0] tgt();
    int r = $urandom_range(9);
    if (r == 0) return 32'hffff_fff8;
    return 32'h1c000000 + 32'($urandom_range(255)) * 4 + (r == 1 ? 32'($urandom_range(1, 3)) : 32'h0);
  endfunction
  initial begin
    int nh, nb, nv, nr, n, bad;
    bit have_prev, got;
    logic [31:0] prev;
    logic [31:0] vpc [3];
    int vcy [3];
    p_addr = 0; p_data = 0; p_allow = 0;
    ex_flush = 0; br_taken = 0; ex_pc = 0; br_target = 0; id_allow_in = 0;
    bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata = 0;
    vpc = '{default: '0};
    vcy = '{default: 0};
    repeat (3) cyc();
    resetn = 1;
    look();
    chk("req_before_first_edge", bus.inst_req, 0);
    p_addr = 100; p_data = 100; p_allow = 100;
    n = 0; bad = 0; nh = 0; have_prev = 0; prev = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      look();
      if (if_valid && n < 3) begin
        vpc[n] = if_pc;
        vcy[n] = i;
        n++;
      end
      if (bus.inst_req && bus.inst_addr_ok) begin
        if (have_prev && bus.inst_addr != prev + 32'd4) bad++;
        prev = bus.inst_addr;
        have_prev = 1;
        nh++;
      end
    end
    chk("stream_pc0", vpc[0], 32'h1c000000);
    chk("stream_pc1", vpc[1], 32'h1c000004);
    chk("stream_pc2", vpc[2], 32'h1c000008);
    chk("stream_consecutive", vcy[2] - vcy[0], 2);
    chk("stream_addr_step_errors", bad, 0);
    chk("stream_hs_every_cycle", nh, 12);
    drain();
    p_allow = 0; p_addr = 100; p_data = 100; nh = 0;
    repeat (12) begin
      cyc();
      look();
      nh += int'(bus.inst_req && bus.inst_addr_ok);
    end
    chk("bp_handshakes", nh, 4);
    chk("bp_req_low", bus.inst_req, 0);
    p_allow = 100;
    cyc();
    look();
    chk("bp_deq_valid", if_valid, 1);
    p_allow = 0; nh = 0;
    repeat (8) begin
      cyc();
      look();
      nh += int'(bus.inst_req && bus.inst_addr_ok);
    end
    chk("bp_one_more_hs", nh, 1);
    drain();
    p_data = 0; p_allow = 100; p_addr = 100; nh = 0;
    for (int i = 0; i < 10 && nh < 3; i++) begin
      cyc();
      look();
      nh += int'(bus.inst_req && bus.inst_addr_ok);
    end
    chk("fl_inflight", nh, 3);
    p_addr = 0;
    cyc();
    br_taken = 1;
    br_target = 32'h1c000100;
    look();
    p_addr = 100; p_data = 100; nb = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      cyc();
      look();
      if (if_valid) got = 1;
      else nb += int'(bus.inst_data_ok);
    end
    chk("fl_valid_seen", got, 1);
    chk("fl_beats_to_first", nb, 4);
    chk("fl_first_pc", if_pc, 32'h1c000100);
    chk("fl_first_inst", if_inst, h(32'h1c000100));
    drain();
    p_data = 0; p_allow = 100; p_addr = 100; nh = 0;
    for (int i = 0; i < 10 && nh < 3; i++) begin
      cyc();
      look();
      nh += int'(bus.inst_req && bus.inst_addr_ok);
    end
    p_addr = 0; p_data = 100;
    cyc();
    ex_flush = 1; br_taken = 1; ex_pc = 32'h1c001000; br_target = 32'h1c000200;
    look();
    chk("sim_coincident_beat", bus.inst_data_ok, 1);
    p_addr = 100; nb = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      cyc();
      look();
      if (i == 0) chk("sim_pc", bus.inst_addr, 32'h1c001000);
      if (if_valid) got = 1;
      else nb += int'(bus.inst_data_ok);
    end
    chk("sim_valid_seen", got, 1);
    chk("sim_beats_to_first", nb, 3);
    chk("sim_first_pc", if_pc, 32'h1c001000);
    drain();
    p_allow = 0; p_addr = 100; p_data = 100;
    cyc();
    br_taken = 1;
    br_target = 32'h1c000102;
    look();
    nr = 0;
    repeat (6) begin
      cyc();
      look();
      nr += int'(bus.inst_req);
    end
    chk("adef_no_req", nr, 0);
    chk("adef_valid", if_valid, 1);
    chk("adef_flag", if_adef, 1);
    chk("adef_pc", if_pc, 32'h1c000102);
    chk("adef_inst", if_inst, 0);
    p_allow = 100; nv = 0;
    repeat (6) begin
      cyc();
      look();
      nv += int'(if_valid);
      nr += int'(bus.inst_req);
    end
    chk("adef_single_entry", nv, 1);
    chk("adef_still_no_req", nr, 0);
    cyc();
    ex_flush = 1;
    ex_pc = 32'h1c000300;
    look();
    cyc();
    look();
    chk("adef_resume_req", bus.inst_req, 1);
    chk("adef_resume_addr", bus.inst_addr, 32'h1c000300);
    drain();
    p_allow = 0; p_addr = 100; p_data = 100;
    repeat (10) cyc();
    look();
    chk("arst_full_valid", if_valid, 1);
    cyc();
    #1;
    resetn = 0;
    bus.inst_addr_ok = 0;
    bus.inst_data_ok = 0;
    #1;
    chk("arst_valid_now", if_valid, 0);
    chk("arst_req_now", bus.inst_req, 0);
    resetn = 1;
    p_allow = 100; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc();
      look();
      got = bus.inst_req;
    end
    chk("arst_req_seen", got, 1);
    chk("arst_first_addr", bus.inst_addr, RESET_PC);
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        p_addr = $urandom_range(30, 100);
        p_data = $urandom_range(30, 100);
        p_allow = $urandom_range(20, 100);
      end
      cyc();
      if ($urandom_range(299) == 0) begin
        #1;
        resetn = 0;
        bus.inst_addr_ok = 0;
        bus.inst_data_ok = 0;
        #1;
        resetn = 1;
      end else if (rnd(4)) begin
        ex_flush = rnd(50);
        br_taken = !ex_flush || rnd(50);
        ex_pc = tgt();
        br_target = tgt();
      end
    end
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", n_chk, n_pass);
    $fatal(1, "timeout");
  end
endmodule
